// File: rtl/game_pkg.sv
// Shared game definitions: match phase encodings, winner codes, ball centre
// coordinates and a saturating score increment.
package game_pkg;

  typedef enum logic [2:0] {
    PH_IDLE       = 3'd0,
    PH_SERVE_WAIT = 3'd1,
    PH_PLAY       = 3'd2,
    PH_GOAL_HOLD  = 3'd3,
    PH_GAME_OVER  = 3'd4
  } phase_e;

  localparam logic [1:0] WINNER_NONE  = 2'b00;
  localparam logic [1:0] WINNER_TEAM1 = 2'b01;
  localparam logic [1:0] WINNER_TEAM2 = 2'b10;

  localparam logic [9:0] BALL_CENTRE_X = 10'd463;
  localparam logic [9:0] BALL_CENTRE_Y = 10'd275;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    if (v == 4'd15) begin
      return v;
    end else begin
      return v + 4'd1;
    end
  endfunction

endpackage

// File: rtl/match_sequencer_if.sv
// Signal bundle between the match sequencer and its surroundings (buttons,
// ball logic, renderer). The slave side is the sequencer itself.
interface match_sequencer_if;

  logic       start_btn;
  logic       goal_team1;
  logic       goal_team2;
  logic       ball_hold;
  logic       ball_enable;
  logic       serve_to_team1;
  logic [3:0] score_team1;
  logic [3:0] score_team2;
  logic [2:0] phase;
  logic [1:0] winner;
  logic [7:0] time_left;

  modport master (
    output start_btn, goal_team1, goal_team2,
    input  ball_hold, ball_enable, serve_to_team1, score_team1, score_team2,
    input  phase, winner, time_left
  );

  modport slave (
    input  start_btn, goal_team1, goal_team2,
    output ball_hold, ball_enable, serve_to_team1, score_team1, score_team2,
    output phase, winner, time_left
  );

endinterface

// File: rtl/button_sync_edge.sv
// Two-flop synchroniser for an active-low push-button followed by a
// falling-edge detector producing a one-cycle press pulse.
module button_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic press_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchroniser chain plus one-cycle history; idles high like the button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= btn_n_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign press_o = prev_q & ~sync_q;

endmodule

// File: rtl/match_sequencer.sv
// Game-flow controller: serve freeze, live play, post-goal freeze, game over.
// Optional match clock enabled by defining MATCH_TIMER_EN.
module match_sequencer
  import game_pkg::*;
#(
  parameter int unsigned WIN_SCORE     = 7,
  parameter int unsigned FREEZE_TICKS  = 50000000,
  parameter int unsigned CLK_HZ        = 50000000,
  parameter int unsigned MATCH_SECONDS = 120
) (
  input  logic             clk,
  input  logic             rst_n,
  match_sequencer_if.slave bus
);

  localparam int unsigned      CNT_W       = $clog2(FREEZE_TICKS + 1);
  localparam logic [CNT_W-1:0] FREEZE_LOAD = CNT_W'(FREEZE_TICKS - 1);
  localparam logic [3:0]       WIN_Q       = 4'(WIN_SCORE);
  // An out-of-range configuration never leaves IDLE/GAME_OVER.
  localparam bit PARAMS_OK = (WIN_SCORE >= 1) && (WIN_SCORE <= 15) &&
                             (FREEZE_TICKS >= 1) && (CLK_HZ >= 1) &&
                             (MATCH_SECONDS >= 1) && (MATCH_SECONDS <= 255);

  phase_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       score1_q, score1_d;
  logic [3:0]       score2_q, score2_d;
  logic             serve_q, serve_d;
  logic [1:0]       winner_q, winner_d;
  logic             hold_q, hold_d;
  logic             enable_q, enable_d;
  logic             start_pulse;
  logic             start_ok;

`ifdef MATCH_TIMER_EN
  localparam int unsigned      PRE_W      = $clog2(CLK_HZ + 1);
  localparam logic [PRE_W-1:0] PRESC_MAX  = PRE_W'(CLK_HZ - 1);
  localparam logic [7:0]       MATCH_LOAD = 8'(MATCH_SECONDS);
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [7:0]       time_left_q, time_left_d;
`endif

  button_sync_edge u_start_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n_i (bus.start_btn),
    .press_o (start_pulse)
  );

  assign start_ok = start_pulse & PARAMS_OK;

  // Next-state and next-output logic for the match FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    score1_d = score1_q;
    score2_d = score2_q;
    serve_d  = serve_q;
    winner_d = winner_q;
`ifdef MATCH_TIMER_EN
    presc_d     = presc_q;
    time_left_d = time_left_q;
    // Seconds prescaler only advances during live play.
    if (state_q == PH_PLAY) begin
      if (presc_q == PRESC_MAX) begin
        presc_d     = '0;
        time_left_d = (time_left_q == 8'd0) ? 8'd0 : (time_left_q - 8'd1);
      end else begin
        presc_d = presc_q + PRE_W'(1);
      end
    end else begin
      presc_d = presc_q;
    end
`endif
    case (state_q)
      PH_IDLE, PH_GAME_OVER: begin
        if (start_ok) begin
          state_d  = PH_SERVE_WAIT;
          cnt_d    = FREEZE_LOAD;
          score1_d = 4'd0;
          score2_d = 4'd0;
          winner_d = WINNER_NONE;
          serve_d  = 1'b1;
`ifdef MATCH_TIMER_EN
          time_left_d = MATCH_LOAD;
          presc_d     = '0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      PH_SERVE_WAIT: begin
        if (cnt_q == '0) begin
          state_d = PH_PLAY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PH_PLAY: begin
        if (bus.goal_team1 && bus.goal_team2) begin
          state_d = PH_GOAL_HOLD;
          cnt_d   = FREEZE_LOAD;
        end else if (bus.goal_team1) begin
          state_d  = PH_GOAL_HOLD;
          cnt_d    = FREEZE_LOAD;
          score1_d = sat_inc4(score1_q);
          serve_d  = 1'b0;
        end else if (bus.goal_team2) begin
          state_d  = PH_GOAL_HOLD;
          cnt_d    = FREEZE_LOAD;
          score2_d = sat_inc4(score2_q);
          serve_d  = 1'b1;
        end
`ifdef MATCH_TIMER_EN
        else if ((time_left_q == 8'd0) && (score1_q != score2_q)) begin
          state_d  = PH_GAME_OVER;
          winner_d = (score1_q > score2_q) ? WINNER_TEAM1 : WINNER_TEAM2;
        end
`endif
        else begin
          state_d = state_q;
        end
      end
      PH_GOAL_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (score1_q == WIN_Q) begin
          state_d  = PH_GAME_OVER;
          winner_d = WINNER_TEAM1;
        end else if (score2_q == WIN_Q) begin
          state_d  = PH_GAME_OVER;
          winner_d = WINNER_TEAM2;
        end
`ifdef MATCH_TIMER_EN
        // Sudden death: clock already expired, first unequal score wins.
        else if ((time_left_q == 8'd0) && (score1_q != score2_q)) begin
          state_d  = PH_GAME_OVER;
          winner_d = (score1_q > score2_q) ? WINNER_TEAM1 : WINNER_TEAM2;
        end
`endif
        else begin
          state_d = PH_PLAY;
        end
      end
      default: begin
        state_d = PH_IDLE;
      end
    endcase
    enable_d = (state_d == PH_PLAY) ? 1'b1 : 1'b0;
    hold_d   = ~enable_d;
  end

  // Match state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PH_IDLE;
      cnt_q    <= '0;
      score1_q <= 4'd0;
      score2_q <= 4'd0;
      serve_q  <= 1'b1;
      winner_q <= WINNER_NONE;
      hold_q   <= 1'b1;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      serve_q  <= serve_d;
      winner_q <= winner_d;
      hold_q   <= hold_d;
      enable_q <= enable_d;
    end
  end

`ifdef MATCH_TIMER_EN
  // Match clock state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      time_left_q <= 8'd0;
    end else begin
      presc_q     <= presc_d;
      time_left_q <= time_left_d;
    end
  end

  assign bus.time_left = time_left_q;
`else
  assign bus.time_left = 8'd0;
`endif

  assign bus.phase          = state_q;
  assign bus.ball_hold      = hold_q;
  assign bus.ball_enable    = enable_q;
  assign bus.serve_to_team1 = serve_q;
  assign bus.score_team1    = score1_q;
  assign bus.score_team2    = score2_q;
  assign bus.winner         = winner_q;

endmodule
